// File: rtl/counter_sequencer.sv
// Run/pause/step controller for the display counter: conditions four push buttons,
// generates the slow count tick and owns the bounded 7-bit count (wrap or saturate).

module btn_cond #(
   parameter int DB_CYCLES = 500_000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic evt
);
   localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   logic          s1, s2, level;
   logic [CW-1:0] cnt;

   // level follows s2 only after DB_CYCLES consecutive samples that disagree with it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
         evt   <= 1'b0;
      end else begin
         s1  <= raw;
         s2  <= s1;
         evt <= 1'b0;
         if (s2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DB_CYCLES - 1)) begin
            level <= s2;
            cnt   <= '0;
            evt   <= s2;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end
endmodule

module counter_sequencer #(
   parameter int TICK_DIV  = 50_000_000,
   parameter int MAX_COUNT = 99,
   parameter int DB_CYCLES = 500_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_run,
   input  logic       btn_step,
   input  logic       btn_dir,
   input  logic       btn_clr,
   input  logic       wrap_en,
   output logic [6:0] count,
   output logic       dir_up,
   output logic       running,
   output logic       at_limit,
   output logic       tick
);
   localparam int NUM_BTN = 4;
   localparam int B_RUN   = 0;
   localparam int B_STEP  = 1;
   localparam int B_DIR   = 2;
   localparam int B_CLR   = 3;
   localparam int PW      = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
   localparam logic [6:0]    MAXC = 7'(MAX_COUNT);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

   logic [NUM_BTN-1:0] btn_raw, btn_evt;
   logic               evt_run, evt_step, evt_dir, evt_clr;
   logic               wrap_s1, wrap_s2;
   state_t             state, state_nxt;
   logic [PW-1:0]      presc;
   logic               adv, sat_hit;
   logic [6:0]         adv_count;

   assign btn_raw = {btn_clr, btn_dir, btn_step, btn_run};

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn (
         .clk (clk),
         .rst (rst),
         .raw (btn_raw[i]),
         .evt (btn_evt[i])
      );
   end

   assign evt_run  = btn_evt[B_RUN];
   assign evt_step = btn_evt[B_STEP];
   assign evt_dir  = btn_evt[B_DIR];
   assign evt_clr  = btn_evt[B_CLR];

   assign tick     = (state == S_RUN) && (presc == PMAX);
   assign at_limit = dir_up ? (count == MAXC) : (count == 7'd0);

   // Advance uses the direction held before any same-cycle dir event
   always_comb begin
      adv       = tick | (evt_step & (state != S_RUN));
      adv_count = count;
      if (dir_up) begin
         if (count < MAXC)  adv_count = count + 7'd1;
         else if (wrap_s2)  adv_count = 7'd0;
      end else begin
         if (count != 7'd0) adv_count = count - 7'd1;
         else if (wrap_s2)  adv_count = MAXC;
      end
      sat_hit = adv & ~wrap_s2 & (adv_count == (dir_up ? MAXC : 7'd0));
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (evt_run) state_nxt = S_RUN;
         S_RUN:   if (evt_run || sat_hit) state_nxt = S_PAUSE;
         S_PAUSE: if (evt_run) state_nxt = S_RUN;
         default: state_nxt = S_IDLE;
      endcase
      if (evt_clr) state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // A run toggle does not cancel a coincident tick advance; clr overrides both
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count   <= 7'd0;
         dir_up  <= 1'b1;
         running <= 1'b0;
         presc   <= '0;
         wrap_s1 <= 1'b0;
         wrap_s2 <= 1'b0;
      end else begin
         wrap_s1 <= wrap_en;
         wrap_s2 <= wrap_s1;
         running <= (state_nxt == S_RUN);
         if (evt_clr)  count <= 7'd0;
         else if (adv) count <= adv_count;
         if (evt_dir) dir_up <= ~dir_up;
         if (evt_clr || (state_nxt == S_RUN && state != S_RUN))
            presc <= '0;
         else if (state == S_RUN)
            presc <= (presc == PMAX) ? '0 : presc + PW'(1);
      end
   end
endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed scenarios plus random button traffic, all
// compared cycle by cycle against a window-based behavioural model.

module tb_counter_sequencer;
   localparam int TICK_DIV = 4;
   localparam int MAXC     = 9;
   localparam int DB       = 3;
   localparam int ST_IDLE  = 0;
   localparam int ST_RUN   = 1;
   localparam int ST_PAUSE = 2;

   logic       clk, rst;
   logic       btn_run, btn_step, btn_dir, btn_clr, wrap_en;
   logic [6:0] count;
   logic       dir_up, running, at_limit, tick;
   logic [10:0] obs;

   int checks = 0;
   int errors = 0;

   // model state
   logic [4:0] hist [0:7];
   logic [3:0] m_db, m_evt;
   logic       m_dir, m_tick;
   int         m_count, m_state, m_age;

   counter_sequencer #(.TICK_DIV(TICK_DIV), .MAX_COUNT(MAXC), .DB_CYCLES(DB)) dut (
      .clk(clk), .rst(rst), .btn_run(btn_run), .btn_step(btn_step), .btn_dir(btn_dir),
      .btn_clr(btn_clr), .wrap_en(wrap_en), .count(count), .dir_up(dir_up),
      .running(running), .at_limit(at_limit), .tick(tick)
   );

   assign obs = {count, dir_up, running, at_limit, tick};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < 8; i++) hist[i] = '0;
      m_db = '0; m_evt = '0; m_dir = 1'b1; m_tick = 1'b0;
      m_count = 0; m_state = ST_IDLE; m_age = 0;
   endtask

   // One clock edge of the model: event flags seen now were produced at the previous edge
   task automatic model_step();
      logic [3:0] new_evt;
      logic       adv, hit, wrap, diff;
      int         nc, ns;
      if (!rst) begin model_reset(); return; end
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {wrap_en, btn_clr, btn_dir, btn_step, btn_run};
      wrap = hist[2][4];
      new_evt = '0;
      for (int b = 0; b < 4; b++) begin
         diff = 1'b1;
         for (int i = 0; i < DB; i++) if (hist[2+i][b] == m_db[b]) diff = 1'b0;
         if (diff) begin m_db[b] = ~m_db[b]; new_evt[b] = m_db[b]; end
      end
      adv = m_tick || (m_evt[1] && m_state != ST_RUN);
      nc = m_count; hit = 1'b0;
      if (adv) begin
         if (m_dir) nc = (m_count < MAXC) ? m_count + 1 : (wrap ? 0 : MAXC);
         else       nc = (m_count > 0) ? m_count - 1 : (wrap ? MAXC : 0);
         hit = !wrap && (nc == (m_dir ? MAXC : 0));
      end
      ns = m_state;
      if (m_evt[3]) begin ns = ST_IDLE; nc = 0; end
      else if (m_evt[0]) ns = (m_state == ST_RUN) ? ST_PAUSE : ST_RUN;
      else if (hit && m_state == ST_RUN) ns = ST_PAUSE;
      if (m_evt[2]) m_dir = ~m_dir;
      if (ns == ST_RUN) m_age = (m_state == ST_RUN) ? m_age + 1 : 0;
      m_state = ns; m_count = nc;
      m_evt = new_evt;
      m_tick = (m_state == ST_RUN) && (m_age % TICK_DIV == TICK_DIV - 1);
   endtask

   function automatic logic [10:0] model_vec();
      logic lim;
      lim = m_dir ? (m_count == MAXC) : (m_count == 0);
      return {7'(m_count), m_dir, (m_state == ST_RUN), lim, m_tick};
   endfunction

   function automatic logic pulse(int c, int s, int n);
      return (c >= s) && (c < s + n);
   endfunction

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      {btn_clr, btn_dir, btn_step, btn_run} = '0;
      wrap_en = 1'b1;
      model_reset();
      repeat (3) cyc();
      checks++;
      if (obs !== {7'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL reset got=%h exp=%h", obs, {7'd0, 4'b1000});
      end
      rst = 1'b1;
   endtask

   task automatic test_run_pause();
      for (int c = 0; c < 40; c++) begin
         btn_run = pulse(c, 0, 6) || pulse(c, 24, 6);
         cyc();
         checks++;
         if (obs !== model_vec()) begin
            errors++; $display("FAIL run_pause c=%0d got=%h exp=%h", c, obs, model_vec());
         end
         if (c == 9 || c == 13 || c == 17) begin
            checks++;
            if (count !== 7'((c - 5) / 4) || running !== 1'b1) begin
               errors++; $display("FAIL run_pause_count c=%0d got=%0d run=%b exp=%0d", c, count, running, (c - 5) / 4);
            end
         end
      end
      checks++;
      if (count !== 7'd6 || running !== 1'b0) begin
         errors++; $display("FAIL run_pause_hold got=%0d run=%b exp=6 run=0", count, running);
      end
   endtask

   task automatic test_wrap_up();
      for (int c = 0; c < 44; c++) begin
         btn_step = pulse(c, 0, 4) || pulse(c, 8, 4);
         btn_run  = pulse(c, 16, 6) || pulse(c, 34, 6);
         cyc();
         checks++;
         if (obs !== model_vec()) begin
            errors++; $display("FAIL wrap_up c=%0d got=%h exp=%h", c, obs, model_vec());
         end
         if (c == 25 || c == 29 || c == 33) begin
            checks++;
            if ({count, at_limit} !== ((c == 25) ? {7'd9, 1'b1} : (c == 29) ? {7'd0, 1'b0} : {7'd1, 1'b0})) begin
               errors++; $display("FAIL wrap_up_seq c=%0d got=%0d lim=%b", c, count, at_limit);
            end
         end
      end
   endtask

   task automatic test_sat_down();
      wrap_en = 1'b0;
      for (int c = 0; c < 42; c++) begin
         btn_dir  = pulse(c, 0, 4);
         btn_step = pulse(c, 8, 4) || pulse(c, 30, 4);
         btn_run  = pulse(c, 16, 6);
         cyc();
         checks++;
         if (obs !== model_vec()) begin
            errors++; $display("FAIL sat_down c=%0d got=%h exp=%h", c, obs, model_vec());
         end
         if (c == 25 || c == 41) begin
            checks++;
            if ({count, running, at_limit} !== {7'd0, 1'b0, 1'b1}) begin
               errors++; $display("FAIL sat_down_hit c=%0d got=%0d run=%b lim=%b exp=0 0 1", c, count, running, at_limit);
            end
         end
      end
   endtask

   task automatic test_step_bounce();
      for (int c = 0; c < 56; c++) begin
         btn_dir  = pulse(c, 0, 4);
         btn_step = pulse(c, 10, 1) || pulse(c, 16, 5) || pulse(c, 36, 4);
         btn_run  = pulse(c, 26, 6) || pulse(c, 44, 6);
         cyc();
         checks++;
         if (obs !== model_vec()) begin
            errors++; $display("FAIL step_bounce c=%0d got=%h exp=%h", c, obs, model_vec());
         end
         if (c == 15 || c == 21 || c == 41 || c == 55) begin
            checks++;
            if (count !== ((c == 15) ? 7'd0 : (c == 21) ? 7'd1 : (c == 41) ? 7'd3 : 7'd5)) begin
               errors++; $display("FAIL step_bounce_count c=%0d got=%0d", c, count);
            end
         end
      end
   endtask

   task automatic test_collisions();
      wrap_en = 1'b1;
      for (int c = 0; c < 46; c++) begin
         btn_clr = pulse(c, 0, 4);
         btn_run = pulse(c, 0, 4) || pulse(c, 10, 6);
         btn_dir = pulse(c, 34, 4);
         cyc();
         checks++;
         if (obs !== model_vec()) begin
            errors++; $display("FAIL collisions c=%0d got=%h exp=%h", c, obs, model_vec());
         end
         if (c == 8) begin
            checks++;
            if ({count, running} !== {7'd0, 1'b0}) begin
               errors++; $display("FAIL clr_run got=%0d run=%b exp=0 0", count, running);
            end
         end
         if (c == 39 || c == 43) begin
            checks++;
            if ({count, dir_up} !== ((c == 39) ? {7'd6, 1'b0} : {7'd5, 1'b0})) begin
               errors++; $display("FAIL dir_tick c=%0d got=%0d dir=%b", c, count, dir_up);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      bit found = 1'b0;
      {btn_clr, btn_dir, btn_step, btn_run} = '0;
      for (int c = 0; c < 200 && !found; c++) begin
         cyc();
         checks++;
         if (obs !== model_vec()) begin
            errors++; $display("FAIL pre_reset c=%0d got=%h exp=%h", c, obs, model_vec());
         end
         if (m_count == 7 && m_state == ST_RUN) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL async_reset_setup got=%0d exp=7 in run", count);
      end
      #2 rst = 1'b0;
      model_reset();
      #1;
      checks++;
      if (obs !== {7'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL async_reset got=%h exp=%h", obs, {7'd0, 4'b1000});
      end
      repeat (2) cyc();
      rst = 1'b1;
      for (int c = 0; c < 30; c++) begin
         btn_run = pulse(c, 20, 6);
         cyc();
         checks++;
         if (obs !== model_vec()) begin
            errors++; $display("FAIL post_reset c=%0d got=%h exp=%h", c, obs, model_vec());
         end
         if (c == 19 || c == 29) begin
            checks++;
            if (running !== (c == 29)) begin
               errors++; $display("FAIL post_reset_run c=%0d got=%b exp=%b", c, running, c == 29);
            end
         end
      end
   endtask

   task automatic test_random();
      int left [4];
      logic [3:0] lvl = '0;
      int wleft = 0;
      for (int b = 0; b < 4; b++) left[b] = 0;
      for (int c = 0; c < 1500; c++) begin
         for (int b = 0; b < 4; b++) begin
            if (left[b] == 0) begin
               lvl[b] = (b == 3) ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
               left[b] = $urandom_range(1, 9);
            end
            left[b]--;
         end
         if (wleft == 0) begin
            wrap_en = 1'($urandom_range(0, 1));
            wleft = $urandom_range(40, 200);
         end
         wleft--;
         {btn_clr, btn_dir, btn_step, btn_run} = lvl;
         cyc();
         checks++;
         if (obs !== model_vec()) begin
            errors++; $display("FAIL random c=%0d got=%h exp=%h", c, obs, model_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_run_pause();
      test_wrap_up();
      test_sat_down();
      test_step_bounce();
      test_collisions();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Run/pause/step controller for the display counter path. Converts raw push-button inputs into a clean start/stop, single-step, direction and clear control set, generates the slow count tick from the system clock, and owns the 7-bit count value with bounded wrap or saturate behaviour. `count` feeds the BCD seven-segment decoder directly.

## Interface
Parameters:
- `TICK_DIV`, default 50_000_000. Clock cycles per count tick in RUN; minimum 2.
- `MAX_COUNT`, default 99. Upper count bound; must be ≤ 127.
- `DB_CYCLES`, default 500_000. Consecutive stable synchronized samples needed before a debounced button level changes; minimum 1.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `btn_run` in 1: raw button, active-high. Each press toggles run/pause.
- `btn_step` in 1: raw button, active-high. Each press advances one step when not running.
- `btn_dir` in 1: raw button, active-high. Each press toggles count direction.
- `btn_clr` in 1: raw button, active-high. Each press clears the count to 0 and goes to IDLE.
- `wrap_en` in 1: level. 1 selects wrap at the bounds; 0 selects saturate at the bounds.
- `count` out 7: current count value, range 0..MAX_COUNT.
- `dir_up` out 1: 1 means counting up, 0 means counting down.
- `running` out 1: high while the FSM is in RUN.
- `at_limit` out 1: high when count is at the bound in the current direction (`MAX_COUNT` going up, 0 going down).
- `tick` out 1: one-cycle pulse on each prescaler terminal count while in RUN.

## Operation
- **Input conditioning (per button):** 2-FF synchronizer, then debounce counter. The debounced level takes the synchronized value after `DB_CYCLES` consecutive identical samples. A one-cycle event pulse fires on each 0→1 transition of the debounced level. `wrap_en` is 2-FF synchronized only.
- **FSM states:** IDLE, RUN, PAUSE.
  - IDLE --run--> RUN.
  - RUN --run--> PAUSE.
  - PAUSE --run--> RUN.
  - Any state --clr--> IDLE.
  - RUN --saturate-hit--> PAUSE.
- **Prescaler:**
  - Counts 0..`TICK_DIV`-1 only in RUN.
  - Cleared to 0 on entering RUN and on clr.
  - `tick` is asserted when the prescaler equals `TICK_DIV`-1.
- **Advance:** occurs on `tick` in RUN, or on a step event in IDLE/PAUSE. Step events in RUN are ignored.
  - Going up: if count < `MAX_COUNT`, count+1. At `MAX_COUNT`: go to 0 if wrap, else hold.
  - Going down: if count > 0, count−1. At 0: go to `MAX_COUNT` if wrap, else hold.
  - Saturate mode in RUN: an advance that lands on the bound moves the FSM to PAUSE in the same cycle.
  - All arithmetic is 7-bit. No intermediate value may exceed `MAX_COUNT` or go below 0.
- **Direction:** a dir event toggles `dir_up` in any state.
- **Priority for events in the same cycle:** clr > run toggle > advance.
  - Dir and advance in the same cycle: the advance uses the old direction.
  - Run toggle and tick in the same cycle: the tick advance is still applied, then the state changes.

## Timing
- **Reset values:** `count`=0, `dir_up`=1, `running`=0, `at_limit`=0, `tick`=0. FSM=IDLE, prescaler=0, synchronizers and debounced levels=0.
- **Button latency:** the event pulse occurs 2 (sync) + `DB_CYCLES` cycles after the raw edge. `count`, `dir_up` and `running` update on the clock edge after the event pulse.
- **Tick spacing:** in RUN, the first tick comes `TICK_DIV` cycles after the RUN entry edge, then every `TICK_DIV` cycles. `count` updates on the edge after `tick` is high.
- **Derived outputs:** `at_limit` is combinational from the registered `count` and `dir_up`. `running` is registered (state==RUN).
- **Reset mid-operation:** asserting `rst` forces all reset values immediately, without waiting for a clock edge. Release is synchronous to `clk` at the next edge.

## Test plan
Bench settings: `TICK_DIV`=4, `MAX_COUNT`=9, `DB_CYCLES`=3.
- **Run/pause:** reset, then press run → `running`=1; `count` reads 1,2,3 at 4-cycle spacing. Press run → `running`=0 and `count` holds.
- **Wrap up:** `wrap_en`=1, up, run from 8 → count goes 9 then 0 then 1; `at_limit`=1 only while count=9.
- **Saturate down:** `wrap_en`=0, down, from count 1 in RUN → count reaches 0, FSM goes to PAUSE, `running`=0, `at_limit`=1. A further step holds count at 0.
- **Step and bounce:** in PAUSE, a run-free 1-cycle glitch on `btn_step` → no change. A clean press → count+1 exactly once. A step press during RUN → ignored.
- **Collisions:** clr and run pressed in the same cycle → IDLE with count=0. Dir event coincident with tick at count 5 going up → count=6, then `dir_up`=0, and the next tick gives 5.
- **Async reset:** assert `rst` mid-RUN at count 7 → all outputs return to reset values with no clock edge. After release, the FSM stays in IDLE until a run press.
